// File: rtl/piso_serializer_pkg.sv
// piso_serializer_pkg
// Shared definitions for the parallel-in/serial-out serializer: the IDLE/SHIFT
// state encoding, the default word width and bit order, and the width helper
// for the bit counter. Imported by the RTL and by the testbench.
package piso_serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam int DEFAULT_WIDTH     = 8;
    localparam int DEFAULT_MSB_FIRST = 1;

    // Bits needed to hold WIDTH-1 (WIDTH is 2..16, so 1..4 bits).
    function automatic int count_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// piso_serializer_if
// Word-in / bit-out bundle of the serializer.
//   din, load   : parallel word and load request (master -> slave)
//   ready       : slave can take a word this cycle (combinational)
//   x, xvalid   : serial bit and its qualifier (registered)
//   last        : x carries the final bit of the word (registered)
//   words       : completed-word counter, modulo 256 (registered)
//   state       : FSM state, for observation only
// Handshake: a word transfers on a rising clk edge where load=1 and ready=1;
// din is sampled only on that edge, and load with ready=0 is dropped, not held.
interface piso_serializer_if
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic [WIDTH-1:0] din;
    logic             load;
    logic             ready;
    logic             x;
    logic             xvalid;
    logic             last;
    logic [7:0]       words;
    state_e           state;

    modport master (
        output din, load,
        input  ready, x, xvalid, last, words, state
    );

    modport slave (
        input  din, load,
        output ready, x, xvalid, last, words, state
    );

endinterface

// File: rtl/piso_serializer_bit_counter.sv
// bit_counter
// Down counter of remaining bits in the current word.
//   clk, reset : clock, asynchronous active-low reset
//   load       : set the count to WIDTH-1 (takes priority over dec)
//   dec        : decrement by one, saturating at zero
//   count      : current count
//   zero       : count == 0
module bit_counter
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CW    = count_width(WIDTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          zero
);

    logic [CW-1:0] count_d;
    logic [CW-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = CW'(WIDTH - 1);
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/piso_serializer.sv
// piso_serializer
// Loads a WIDTH-bit word and shifts it out one bit per clock, MSB or LSB first.
// Back-to-back words run with no gap when a new word is loaded during last.
//   clk   : clock
//   reset : asynchronous active-low reset
//   bus   : slave side of piso_serializer_if (din/load/ready in,
//           x/xvalid/last/words/state out)
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MSB_FIRST = DEFAULT_MSB_FIRST
) (
    input  logic                clk,
    input  logic                reset,
    piso_serializer_if.slave    bus
);

    localparam int CW = count_width(WIDTH);

    state_e           state_d,  state_q;
    logic [WIDTH-1:0] shreg_d,  shreg_q;
    logic             x_d,      x_q;
    logic             xvalid_d, xvalid_q;
    logic             last_d,   last_q;
    logic [7:0]       words_d,  words_q;

    logic [CW-1:0]    count;
    logic             cnt_zero;
    logic             ready_int;
    logic             accept;
    logic             advance;

    // Head bit and remainder. x is registered, so the head bit goes straight
    // to x_q and the shift register keeps only the bits still to be sent.
    logic             din_head,   shreg_head;
    logic [WIDTH-1:0] din_rest,   shreg_rest;

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign din_head   = bus.din[WIDTH-1];
            assign din_rest   = {bus.din[WIDTH-2:0], 1'b0};
            assign shreg_head = shreg_q[WIDTH-1];
            assign shreg_rest = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign din_head   = bus.din[0];
            assign din_rest   = {1'b0, bus.din[WIDTH-1:1]};
            assign shreg_head = shreg_q[0];
            assign shreg_rest = {1'b0, shreg_q[WIDTH-1:1]};
        end
    endgenerate

    // ready is low while reset is asserted and otherwise open in IDLE or on
    // the final bit of a word, which is what allows gapless chaining.
    assign ready_int = reset & ((state_q == ST_IDLE) | last_q);
    assign accept    = bus.load & ready_int;
    assign advance   = (state_q == ST_SHIFT) & ~last_q & ~cnt_zero;

    bit_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_bit_counter (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .dec   (advance),
        .count (count),
        .zero  (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        x_d      = x_q;
        xvalid_d = xvalid_q;
        last_d   = last_q;
        words_d  = words_q;

        // Every final bit counts, whether or not a new word follows.
        if (last_q) begin
            words_d = words_q + 8'd1;
        end

        if (accept) begin
            state_d  = ST_SHIFT;
            x_d      = din_head;
            shreg_d  = din_rest;
            xvalid_d = 1'b1;
            last_d   = 1'b0;
        end else if (last_q) begin
            state_d  = ST_IDLE;
            x_d      = 1'b0;
            shreg_d  = '0;
            xvalid_d = 1'b0;
            last_d   = 1'b0;
        end else if (advance) begin
            x_d      = shreg_head;
            shreg_d  = shreg_rest;
            // count is one ahead of the bit now going to x.
            last_d   = (count == CW'(1));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            x_q      <= 1'b0;
            xvalid_q <= 1'b0;
            last_q   <= 1'b0;
            words_q  <= 8'd0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            x_q      <= x_d;
            xvalid_q <= xvalid_d;
            last_q   <= last_d;
            words_q  <= words_d;
        end
    end

    assign bus.ready  = ready_int;
    assign bus.x      = x_q;
    assign bus.xvalid = xvalid_q;
    assign bus.last   = last_q;
    assign bus.words  = words_q;
    assign bus.state  = state_q;

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer
// Directed bench for piso_serializer: an 8-bit MSB-first instance, an 8-bit
// LSB-first instance and a 4-bit MSB-first instance whose stream drives
// Mealy and Moore "1000" detectors. All instances share clk and reset.
module tb_piso_serializer;
    import piso_serializer_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    piso_serializer_if #(.WIDTH(DEFAULT_WIDTH)) b8  ();
    piso_serializer_if #(.WIDTH(8))             b8l ();
    piso_serializer_if #(.WIDTH(4))             b4  ();

    piso_serializer #(.WIDTH(DEFAULT_WIDTH), .MSB_FIRST(DEFAULT_MSB_FIRST)) u_dut8 (
        .clk(clk), .reset(reset), .bus(b8.slave)
    );
    piso_serializer #(.WIDTH(8), .MSB_FIRST(0)) u_dut8l (
        .clk(clk), .reset(reset), .bus(b8l.slave)
    );
    piso_serializer #(.WIDTH(4), .MSB_FIRST(1)) u_dut4 (
        .clk(clk), .reset(reset), .bus(b4.slave)
    );

    // "1000" detector on the 4-bit stream: states count the matched prefix.
    logic [2:0] det_q;
    logic       mealy_out;
    logic       moore_out;

    function automatic logic [2:0] det_next(input logic [2:0] s, input logic xb);
        if (xb) return 3'd1;
        case (s)
            3'd1:    return 3'd2;
            3'd2:    return 3'd3;
            3'd3:    return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) det_q <= 3'd0;
        else        det_q <= det_next(det_q, b4.x);
    end

    assign mealy_out = (det_q == 3'd3) && !b4.x;
    assign moore_out = (det_q == 3'd4);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called one cycle after the accepting edge; walks the 8 bits of w on b8.
    // chain: load nxt during last. poke: cycle index where a (to be ignored)
    // load of 8'hFF is pulsed. din is scrambled on all other cycles.
    task automatic expect_word8(input logic [7:0] w, input bit chain,
                                input logic [7:0] nxt, input int poke);
        for (int i = 0; i < 8; i++) begin
            check("b8_x",      b8.x,      w[7-i]);
            check("b8_xvalid", b8.xvalid, 1);
            check("b8_last",   b8.last,   (i == 7));
            check("b8_ready",  b8.ready,  (i == 7));
            if (i == 7 && chain) begin
                b8.load = 1'b1; b8.din = nxt;
            end else if (i == poke) begin
                b8.load = 1'b1; b8.din = 8'hFF;
            end else begin
                b8.load = 1'b0; b8.din = ~w;
            end
            step();
        end
        b8.load = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] lw8;
        logic [3:0] lw4;

        b8.din  = '0; b8.load  = 1'b0;
        b8l.din = '0; b8l.load = 1'b0;
        b4.din  = '0; b4.load  = 1'b0;

        // Reset held: everything idle, ready low.
        #12;
        check("rst_x",      b8.x,      0);
        check("rst_xvalid", b8.xvalid, 0);
        check("rst_last",   b8.last,   0);
        check("rst_ready",  b8.ready,  0);
        check("rst_words",  b8.words,  0);
        check("rst_state",  b8.state,  ST_IDLE);
        check("rst_ready4", b4.ready,  0);

        // Release with a load already waiting for the first edge.
        @(negedge clk);
        reset = 1'b1;
        b8.din = 8'b1000_0000; b8.load = 1'b1;
        #1;
        check("rel_ready", b8.ready, 1);
        step();
        expect_word8(8'b1000_0000, 1'b0, 8'h00, -1);
        check("w1_words",  b8.words,  1);
        check("w1_xvalid", b8.xvalid, 0);
        check("w1_x",      b8.x,      0);
        check("w1_state",  b8.state,  ST_IDLE);
        check("w1_ready",  b8.ready,  1);

        // Back-to-back A5 then 0F: 16 contiguous bits, two more words.
        b8.din = 8'hA5; b8.load = 1'b1;
        step();
        expect_word8(8'hA5, 1'b1, 8'h0F, -1);
        expect_word8(8'h0F, 1'b0, 8'h00, -1);
        check("b2b_words",  b8.words,  3);
        check("b2b_xvalid", b8.xvalid, 0);

        // Load pulsed mid-word is ignored; word completes, block idles.
        b8.din = 8'h3C; b8.load = 1'b1;
        step();
        expect_word8(8'h3C, 1'b0, 8'h00, 3);
        check("ign_words", b8.words, 4);
        check("ign_state", b8.state, ST_IDLE);
        step();
        check("ign_xvalid", b8.xvalid, 0);

        // LSB-first instance: A5 goes out bit 0 first.
        lw8 = 8'hA5;
        b8l.din = lw8; b8l.load = 1'b1;
        step();
        b8l.load = 1'b0; b8l.din = 8'h00;
        for (int i = 0; i < 8; i++) begin
            check("b8l_x",    b8l.x,    lw8[i]);
            check("b8l_last", b8l.last, (i == 7));
            step();
        end
        check("b8l_words", b8l.words, 1);

        // 4-bit 1000 into the detectors: Mealy on the 4th bit, Moore after.
        b4.din = 4'b1000; b4.load = 1'b1;
        step();
        b4.load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("b4_x",     b4.x,      (i == 0));
            check("b4_last",  b4.last,   (i == 3));
            check("mealy",    mealy_out, (i == 3));
            check("moore_lo", moore_out, 0);
            step();
        end
        check("moore_hi",  moore_out, 1);
        check("mealy_lo",  mealy_out, 0);
        check("b4_words",  b4.words,  1);

        // Reset during the fifth bit of an FF word aborts it immediately.
        b8.din = 8'hFF; b8.load = 1'b1;
        step();
        b8.load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("ab_x", b8.x, 1);
            step();
        end
        check("ab_pre_xvalid", b8.xvalid, 1);
        reset = 1'b0;
        #1;
        check("ab_x0",      b8.x,      0);
        check("ab_xvalid0", b8.xvalid, 0);
        check("ab_ready0",  b8.ready,  0);
        check("ab_last0",   b8.last,   0);
        check("ab_words0",  b8.words,  0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("ab_ready1", b8.ready, 1);
        check("ab_words1", b8.words, 0);
        step();
        check("ab_post_xvalid", b8.xvalid, 0);
        check("ab_post_x",      b8.x,      0);

        // 256 gapless 4-bit words: words reads 255 during the last one, then 0.
        lw4 = 4'b0110;
        b4.din = lw4; b4.load = 1'b1;
        step();
        for (int k = 0; k < 256; k++) begin
            for (int i = 0; i < 4; i++) begin
                check("wr_xvalid", b4.xvalid, 1);
                check("wr_x",      b4.x,      lw4[3-i]);
                if (i == 3) check("wr_last", b4.last, 1);
                if (i == 3 && k == 0)   check("wr_words0",   b4.words, 0);
                if (i == 3 && k == 255) check("wr_words255", b4.words, 255);
                b4.load = (i == 3 && k < 255);
                step();
            end
        end
        b4.load = 1'b0;
        check("wr_wrap",       b4.words,  0);
        check("wr_end_xvalid", b4.xvalid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
